// File: rtl/dlx_pkg.sv
// Shared DLX definitions: opcode constants, IF/ID bubble word and resolver FSM encoding.
package dlx_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_J    = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL  = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQZ = 6'h04;
  localparam logic [OP_W-1:0] OP_BNEZ = 6'h05;
  localparam logic [OP_W-1:0] OP_JR   = 6'h12;
  localparam logic [OP_W-1:0] OP_JALR = 6'h13;

  localparam logic [XLEN-1:0] BUBBLE = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } state_t;

endpackage

// File: rtl/leap_resolve_decode.sv
// Combinational decode of the IF/ID word: control-transfer class, branch outcome and target.
import dlx_pkg::*;

module leap_decode (
  input  logic [0:31] id_instr,
  input  logic [0:31] id_pcplus4,
  input  logic [0:31] rs1_data,
  output logic        is_ctrl,
  output logic        needs_rs1,
  output logic        taken,
  output logic        is_link,
  output logic [0:31] target
);

  logic [OP_W-1:0] opcode;
  logic [XLEN-1:0] off26;
  logic [XLEN-1:0] off16;
  logic            rs1_zero;

  assign opcode   = id_instr[0:5];
  assign off26    = {{6{id_instr[6]}}, id_instr[6:31]};
  assign off16    = {{16{id_instr[16]}}, id_instr[16:31]};
  assign rs1_zero = (rs1_data == '0);

  always_comb begin
    is_ctrl   = 1'b0;
    needs_rs1 = 1'b0;
    taken     = 1'b0;
    is_link   = 1'b0;
    target    = '0;
    case (opcode)
      OP_J, OP_JAL: begin
        is_ctrl = 1'b1;
        taken   = 1'b1;
        is_link = (opcode == OP_JAL);
        target  = id_pcplus4 + off26;
      end
      OP_BEQZ, OP_BNEZ: begin
        is_ctrl   = 1'b1;
        needs_rs1 = 1'b1;
        taken     = (opcode == OP_BEQZ) ? rs1_zero : !rs1_zero;
        target    = id_pcplus4 + off16;
      end
      OP_JR, OP_JALR: begin
        is_ctrl   = 1'b1;
        needs_rs1 = 1'b1;
        taken     = 1'b1;
        is_link   = (opcode == OP_JALR);
        target    = rs1_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/register32.sv
// 32-bit register with write enable and asynchronous active-high clear.
module register32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_enable,
  input  logic [0:31] d,
  output logic [0:31] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (write_enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/leap_resolve.sv
// ID-stage control-transfer resolver: IF/ID register, redirect/squash/stall FSM,
// link write for JAL/JALR and a saturating taken-leap counter.
import dlx_pkg::*;

module leap_resolve #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:31]      pcplus4_in,
  input  logic [0:31]      instr_in,
  input  logic [0:31]      rs1_data,
  input  logic             rs1_ready,
  output logic             leap,
  output logic [0:31]      leap_addr,
  output logic             pc_hold,
  output logic [0:31]      id_instr,
  output logic [0:31]      id_pcplus4,
  output logic             id_valid,
  output logic             link_we,
  output logic [0:31]      link_value,
  output logic [0:CNT_W-1] leap_count
);

  state_t      state;
  state_t      next_state;
  logic        is_ctrl;
  logic        needs_rs1;
  logic        taken;
  logic        is_link;
  logic [0:31] target;
  logic        ifid_we;
  logic        load_bubble;
  logic [0:31] instr_d;
  logic [0:31] pcplus4_d;

  leap_decode u_decode (
    .id_instr   (id_instr),
    .id_pcplus4 (id_pcplus4),
    .rs1_data   (rs1_data),
    .is_ctrl    (is_ctrl),
    .needs_rs1  (needs_rs1),
    .taken      (taken),
    .is_link    (is_link),
    .target     (target)
  );

  assign instr_d    = load_bubble ? BUBBLE : instr_in;
  assign pcplus4_d  = load_bubble ? '0 : pcplus4_in;
  assign link_value = id_pcplus4;

  register32 u_ifid_instr (
    .clk          (clk),
    .reset        (reset),
    .write_enable (ifid_we),
    .d            (instr_d),
    .q            (id_instr)
  );

  register32 u_ifid_pcplus4 (
    .clk          (clk),
    .reset        (reset),
    .write_enable (ifid_we),
    .d            (pcplus4_d),
    .q            (id_pcplus4)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_valid <= 1'b0;
    end else if (ifid_we) begin
      id_valid <= !load_bubble;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leap_count <= '0;
    end else if (leap && (leap_count != '1)) begin
      leap_count <= leap_count + CNT_W'(1);
    end
  end

  // HOLD re-resolves every cycle exactly like RUN; a stall always wins over a redirect.
  always_comb begin
    next_state  = state;
    leap        = 1'b0;
    leap_addr   = '0;
    pc_hold     = 1'b0;
    link_we     = 1'b0;
    ifid_we     = 1'b1;
    load_bubble = 1'b0;
    case (state)
      RUN, HOLD: begin
        if (id_valid && needs_rs1 && !rs1_ready) begin
          next_state = HOLD;
          pc_hold    = 1'b1;
          ifid_we    = 1'b0;
        end else if (id_valid && is_ctrl && taken) begin
          next_state  = SQUASH;
          leap        = 1'b1;
          leap_addr   = target;
          link_we     = is_link;
          load_bubble = 1'b1;
        end else begin
          next_state = RUN;
        end
      end
      SQUASH: next_state = RUN;
      default: next_state = RUN;
    endcase
  end

endmodule

// File: tb/tb_leap_resolve.sv
// Scoreboard bench for leap_resolve: per-cycle expected ID-stage state is queued
// as stimulus is driven and compared against the DUT a moment later.
module tb_leap_resolve;

  localparam int unsigned CNT_W = 4;

  localparam logic [31:0] W_ADDI  = 32'h2001_0005;
  localparam logic [31:0] W_ADDI2 = 32'h2003_0007;
  localparam logic [31:0] W_NOP   = 32'h2002_0001;
  localparam logic [31:0] W_J10   = 32'h0800_0010;
  localparam logic [31:0] W_JAL20 = 32'h0C00_0020;
  localparam logic [31:0] W_BEQZ  = 32'h1020_FFF8;
  localparam logic [31:0] W_BNEZ  = 32'h1420_0008;
  localparam logic [31:0] W_JALR  = 32'h4C20_0000;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      pcplus4_in;
  logic [31:0]      instr_in;
  logic [31:0]      rs1_data;
  logic             rs1_ready;
  logic             leap;
  logic [31:0]      leap_addr;
  logic             pc_hold;
  logic [31:0]      id_instr;
  logic [31:0]      id_pcplus4;
  logic             id_valid;
  logic             link_we;
  logic [31:0]      link_value;
  logic [CNT_W-1:0] leap_count;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        leap;
    logic [31:0] addr;
    logic        hold;
    logic        lwe;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  leap_resolve #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .pcplus4_in (pcplus4_in),
    .instr_in   (instr_in),
    .rs1_data   (rs1_data),
    .rs1_ready  (rs1_ready),
    .leap       (leap),
    .leap_addr  (leap_addr),
    .pc_hold    (pc_hold),
    .id_instr   (id_instr),
    .id_pcplus4 (id_pcplus4),
    .id_valid   (id_valid),
    .link_we    (link_we),
    .link_value (link_value),
    .leap_count (leap_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc4,
                              input logic valid, input logic lp, input logic [31:0] addr,
                              input logic hold, input logic lwe);
    exp_t e;
    e.instr = instr;
    e.pc4   = pc4;
    e.valid = valid;
    e.leap  = lp;
    e.addr  = addr;
    e.hold  = hold;
    e.lwe   = lwe;
    return e;
  endfunction

  function automatic exp_t bubble();
    return mk(32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    e = sb.pop_front();
    check_eq("id_instr", id_instr, e.instr);
    check_eq("id_valid", 32'(id_valid), 32'(e.valid));
    if (e.valid) check_eq("id_pcplus4", id_pcplus4, e.pc4);
    check_eq("leap", 32'(leap), 32'(e.leap));
    if (e.leap) check_eq("leap_addr", leap_addr, e.addr);
    check_eq("pc_hold", 32'(pc_hold), 32'(e.hold));
    check_eq("link_we", 32'(link_we), 32'(e.lwe));
    if (e.lwe) check_eq("link_value", link_value, e.pc4);
  endtask

  // Drive one fetch cycle and compare the ID-stage view for that same cycle.
  task automatic apply(input logic [31:0] instr, input logic [31:0] pc4,
                       input logic [31:0] rs1, input logic rdy, input exp_t e);
    @(negedge clk);
    instr_in   = instr;
    pcplus4_in = pc4;
    rs1_data   = rs1;
    rs1_ready  = rdy;
    sb.push_back(e);
    #1;
    compare_front();
  endtask

  initial begin
    reset      = 1'b1;
    instr_in   = W_ADDI;
    pcplus4_in = 32'h4;
    rs1_data   = 32'h0;
    rs1_ready  = 1'b1;
    #2;
    sb.push_back(bubble());
    compare_front();
    check_eq("rst_leap_addr", leap_addr, 32'h0);
    check_eq("rst_count", 32'(leap_count), 32'h0);

    @(negedge clk);
    reset = 1'b0;
    sb.push_back(bubble());
    #1;
    compare_front();

    // ADDI enters, then J +0x10 with one bubble before the target word
    apply(W_J10,   32'h104, 32'h0, 1'b1, mk(W_ADDI, 32'h4, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0));
    apply(W_NOP,   32'h108, 32'h0, 1'b1, mk(W_J10, 32'h104, 1'b1, 1'b1, 32'h114, 1'b0, 1'b0));
    apply(W_ADDI2, 32'h118, 32'h0, 1'b1, bubble());
    check_eq("count_j", 32'(leap_count), 32'd1);

    // BEQZ -8: taken with rs1=0, then not taken with rs1=5
    apply(W_BEQZ,  32'h200, 32'h0, 1'b1, mk(W_ADDI2, 32'h118, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0));
    apply(W_NOP,   32'h204, 32'h0, 1'b1, mk(W_BEQZ, 32'h200, 1'b1, 1'b1, 32'h1F8, 1'b0, 1'b0));
    apply(W_BEQZ,  32'h200, 32'h0, 1'b1, bubble());
    check_eq("count_beqz", 32'(leap_count), 32'd2);
    apply(W_ADDI,  32'h204, 32'h5, 1'b1, mk(W_BEQZ, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0));

    // JALR stalled two cycles, then resolves with link
    apply(W_JALR,  32'h208, 32'h0, 1'b1, mk(W_ADDI, 32'h204, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0));
    apply(W_NOP,   32'h20C, 32'h0, 1'b0, mk(W_JALR, 32'h208, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0));
    apply(W_NOP,   32'h20C, 32'h0, 1'b0, mk(W_JALR, 32'h208, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0));
    apply(W_NOP,   32'h20C, 32'h3000, 1'b1, mk(W_JALR, 32'h208, 1'b1, 1'b1, 32'h3000, 1'b0, 1'b1));

    // Target word is itself a JAL: back-to-back leaps
    apply(W_JAL20, 32'h3004, 32'h0, 1'b1, bubble());
    check_eq("count_jalr", 32'(leap_count), 32'd3);
    apply(W_NOP,   32'h3008, 32'h0, 1'b1, mk(W_JAL20, 32'h3004, 1'b1, 1'b1, 32'h3024, 1'b0, 1'b1));

    // BNEZ +8 at pcplus4 0xFFFF_FFFC wraps to 0x4
    apply(W_BNEZ,  32'hFFFF_FFFC, 32'h0, 1'b1, bubble());
    apply(W_NOP,   32'h0, 32'h1, 1'b1, mk(W_BNEZ, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h4, 1'b0, 1'b0));

    // Reset asserted while in SQUASH
    @(negedge clk);
    check_eq("count_pre_rst", 32'(leap_count), 32'd5);
    reset      = 1'b1;
    instr_in   = W_J10;
    pcplus4_in = 32'h400;
    rs1_data   = 32'h0;
    rs1_ready  = 1'b1;
    sb.push_back(bubble());
    #1;
    compare_front();
    check_eq("count_rst", 32'(leap_count), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    sb.push_back(bubble());
    #1;
    compare_front();

    // 2^CNT_W+3 back-to-back taken J's: counter must stick at all-ones
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      apply(W_J10, 32'h400, 32'h0, 1'b1, mk(W_J10, 32'h400, 1'b1, 1'b1, 32'h410, 1'b0, 1'b0));
      apply(W_J10, 32'h400, 32'h0, 1'b1, bubble());
      check_eq("count_sat", 32'(leap_count),
               (i + 1 > (1 << CNT_W) - 1) ? 32'((1 << CNT_W) - 1) : 32'(i + 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
